lsu_master: RTL

- Load/store initiator between the CPU memory stage and a word-organised data memory.
- Takes one load or store op per transaction from the pipeline and turns it into a word-aligned memory request with byte enables and lane-shifted write data.
- On loads, extracts and sign/zero-extends the addressed byte/half/word from the returned word.
- Runs a req/ack handshake toward memory, so the memory can take a variable number of cycles; flags misalignment and timeout.

---
 rtl/lsu_master.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_master
// Description : Load/store initiator: turns one pipeline memory op into a
//               word-aligned req/ack memory transaction with byte enables,
//               lane-shifted store data and extended load data.
//               Optional store trace printing when LSU_TRACE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_master #(
    parameter int TIMEOUT     = 255,
    parameter int WORD_ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_type,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic [31:0] op_pc,
    output logic        res_valid,
    output logic [31:0] res_rdata,
    output logic        res_exc,
    output logic        res_exc_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [63:0] C_ADDR_SPAN = (64'd1 << (WORD_ADDR_W + 2)) - 64'd1;
    localparam logic [31:0] C_ADDR_MASK = C_ADDR_SPAN[31:0] & 32'hFFFF_FFFC;
    localparam logic [9:0]  C_TIMEOUT   = 10'(TIMEOUT);

    state_t      state_q, state_d;
    logic [2:0]  type_q, type_d;
    logic [1:0]  off_q, off_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        mis_q, mis_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] res_rdata_q, res_rdata_d;
    logic        res_exc_q, res_exc_d;
    logic        res_exc_code_q, res_exc_code_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

`ifdef LSU_TRACE_EN
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
`else
    logic        w_unused_pc;
    assign w_unused_pc = ^op_pc;
`endif

    logic        w_op_store;
    logic        w_size_word;
    logic        w_size_half;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_store_q;
    logic [15:0] w_lane;
    logic [31:0] w_load;

    // Decode of the op presented on the pipeline side
    always_comb begin
        w_op_store  = op_type[2] & (op_type[1] | op_type[0]);
        w_size_word = 1'b0;
        w_size_half = 1'b0;
        case (op_type)
            3'b000, 3'b101:         w_size_word = 1'b1;
            3'b001, 3'b010, 3'b110: w_size_half = 1'b1;
            default:                ;
        endcase

        if (w_size_word) begin
            w_misaligned = (op_addr[1:0] != 2'b00);
            w_be         = 4'b1111;
            w_wdata      = op_wdata;
        end else if (w_size_half) begin
            w_misaligned = op_addr[0];
            w_be         = 4'b0011 << op_addr[1:0];
            w_wdata      = {2{op_wdata[15:0]}};
        end else begin
            w_misaligned = 1'b0;
            w_be         = 4'b0001 << op_addr[1:0];
            w_wdata      = {4{op_wdata[7:0]}};
        end
        if (!w_op_store) begin
            w_be    = 4'b1111;
            w_wdata = 32'h0;
        end
    end

    // Load extraction from the returned word, using the latched op
    always_comb begin
        w_store_q = type_q[2] & (type_q[1] | type_q[0]);
        w_lane    = 16'(mem_rdata >> {off_q, 3'b000});
        case (type_q)
            3'b000:  w_load = mem_rdata;
            3'b001:  w_load = {{16{w_lane[15]}}, w_lane};
            3'b010:  w_load = {16'h0, w_lane};
            3'b011:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b100:  w_load = {24'h0, w_lane[7:0]};
            default: w_load = 32'h0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        type_d         = type_q;
        off_d          = off_q;
        cnt_d          = cnt_q;
        mis_d          = mis_q;
        res_valid_d    = 1'b0;
        res_rdata_d    = 32'h0;
        res_exc_d      = 1'b0;
        res_exc_code_d = 1'b0;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_be_d       = mem_be_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
`ifdef LSU_TRACE_EN
        pc_d           = pc_q;
        addr_d         = addr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    type_d = op_type;
                    off_d  = op_addr[1:0];
                    cnt_d  = 10'd0;
`ifdef LSU_TRACE_EN
                    pc_d   = op_pc;
                    addr_d = op_addr;
`endif
                    if (w_misaligned) begin
                        mis_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = w_op_store;
                        mem_be_d    = w_be;
                        mem_addr_d  = op_addr & C_ADDR_MASK;
                        mem_wdata_d = w_wdata;
                    end
                end
            end
            S_REQ: begin
                // An ack in the final timeout cycle still completes the op
                if (mem_ack) begin
                    state_d     = S_RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'b0000;
                    cnt_d       = 10'd0;
                    res_valid_d = 1'b1;
                    res_rdata_d = w_store_q ? 32'h0 : w_load;
                end else if (cnt_q + 10'd1 == C_TIMEOUT) begin
                    state_d        = S_RESP;
                    mem_req_d      = 1'b0;
                    mem_we_d       = 1'b0;
                    mem_be_d       = 4'b0000;
                    cnt_d          = 10'd0;
                    res_valid_d    = 1'b1;
                    res_exc_d      = 1'b1;
                    res_exc_code_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            S_RESP: begin
                // Misaligned ops spend one extra cycle here before reporting
                if (mis_q) begin
                    mis_d       = 1'b0;
                    res_valid_d = 1'b1;
                    res_exc_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            type_q         <= 3'b000;
            off_q          <= 2'b00;
            cnt_q          <= 10'd0;
            mis_q          <= 1'b0;
            res_valid_q    <= 1'b0;
            res_rdata_q    <= 32'h0;
            res_exc_q      <= 1'b0;
            res_exc_code_q <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_be_q       <= 4'b0000;
            mem_addr_q     <= 32'h0;
            mem_wdata_q    <= 32'h0;
`ifdef LSU_TRACE_EN
            pc_q           <= 32'h0;
            addr_q         <= 32'h0;
`endif
        end else begin
            state_q        <= state_d;
            type_q         <= type_d;
            off_q          <= off_d;
            cnt_q          <= cnt_d;
            mis_q          <= mis_d;
            res_valid_q    <= res_valid_d;
            res_rdata_q    <= res_rdata_d;
            res_exc_q      <= res_exc_d;
            res_exc_code_q <= res_exc_code_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_be_q       <= mem_be_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
`ifdef LSU_TRACE_EN
            pc_q           <= pc_d;
            addr_q         <= addr_d;
`endif
        end
    end

`ifdef LSU_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_REQ && mem_ack && mem_we_q) begin
            $display("@%h: *%h <= %h", pc_q, addr_q,
                     mem_wdata_q & {{8{mem_be_q[3]}}, {8{mem_be_q[2]}},
                                    {8{mem_be_q[1]}}, {8{mem_be_q[0]}}});
        end
    end
`endif

    assign op_ready     = (state_q == S_IDLE);
    assign res_valid    = res_valid_q;
    assign res_rdata    = res_rdata_q;
    assign res_exc      = res_exc_q;
    assign res_exc_code = res_exc_code_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_be       = mem_be_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule
`default_nettype wire
